verificador_decrescente_6bits: RTL
==================================

# verificador_decrescente_6bits

Synchronous checker that sits directly downstream of the 6-bit ripple down-counter. It samples the counter value and verifies that each sample is exactly one below the previous one, modulo 2^WIDTH. It declares lock after a run of correct steps, then reports each wrap-around (0 → max) and each sequence error, keeping saturating event counters. It is the self-check stage for the counter on the bench and in the integrated design.

## Interface
- WIDTH, 6, width of the counter value being checked
- LOCK_N, 4, consecutive correct steps required to assert `locked` (≥1)
- CNT_W, 8, width of `wrap_cnt` and `err_cnt`

- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  sample strobe; `q_in` is sampled on a posedge only when `en`=1
- q_in  in  WIDTH  counter value from the down-counter
- locked  out  1  high while the sequence is tracked correctly
- err  out  1  one-cycle pulse on a sequence mismatch while locked
- wrap  out  1  one-cycle pulse on a correct 0 → 2^WIDTH−1 step while locked
- expected  out  WIDTH  next value expected; equals last sample − 1 mod 2^WIDTH
- wrap_cnt  out  CNT_W  count of `wrap` pulses, saturating at 2^CNT_W−1
- err_cnt  out  CNT_W  count of `err` pulses, saturating at 2^CNT_W−1

## Operation
- Internal state: FSM {EMPTY, ACQ, LOCK}, `prev` register (WIDTH bits), `good` step counter (range 0..LOCK_N).
- A step is correct when `q_in == prev − 1` mod 2^WIDTH. Subtraction wraps, so `prev`=0 expects 2^WIDTH−1.
- `en`=0: FSM, `prev`, `good`, counters, `locked` and `expected` all hold. `err` and `wrap` are 0.
- EMPTY with `en`=1: load `prev` ← `q_in`, `good` ← 0, go to ACQ. No comparison is made on this sample.
- ACQ with `en`=1:
  - Correct step: `good`+1. When `good`+1 == LOCK_N, go to LOCK and set `locked`=1.
  - Incorrect step: `good` ← 0, stay in ACQ.
  - No `err` or `wrap` pulse is produced in ACQ.
- LOCK with `en`=1:
  - Correct step: stay in LOCK. If `prev`=0 (so `q_in` = 2^WIDTH−1), pulse `wrap` and increment `wrap_cnt`.
  - Incorrect step: pulse `err`, increment `err_cnt`, clear `locked`, go to ACQ with `good` ← 0.
- Every sample taken with `en`=1, in any state, loads `prev` ← `q_in`. `expected` always tracks `prev` − 1.
- Counters saturate: once at 2^CNT_W−1, further events still pulse `err`/`wrap`, but the count holds.
- FSM encoding is 2 bits. The unused encoding returns to EMPTY on the next posedge.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately, including mid-operation):
  - state EMPTY, `prev`=0, `good`=0.
  - Outputs: `locked`=0, `err`=0, `wrap`=0, `expected`=0, `wrap_cnt`=0, `err_cnt`=0.
- Reset release is sampled on posedge. The first posedge with `rst_n`=1 and `en`=1 is the first sample.
- All outputs are registered. Latency is 1 cycle: the effect of a sample taken at posedge N is visible right after posedge N and holds until posedge N+1.
- `err` and `wrap` are high for exactly one cycle per event. A sample can never produce both.
- `locked` rises right after the posedge of the LOCK_N-th consecutive correct step. It falls right after the posedge of the first mismatch.
- `en` may be gapped arbitrarily. Only `en`=1 edges count as steps, and gaps never break lock.

## Test plan
- Reset check: hold `rst_n`=0 → all outputs 0. Release with `en`=0 for 10 cycles → all outputs stay 0.
- Lock acquisition (LOCK_N=4): feed 63, 62, 61, 60, 59 with `en`=1 each cycle → `locked`=1 right after the edge sampling 59, `expected`=58, `err`=0 throughout.
- Wrap-around: while locked, feed 1, 0, 63 → `wrap` pulses for one cycle after the 63 sample, `wrap_cnt`=1, `expected`=62, `locked` stays 1.
- Error and relock: while locked with `prev`=40, feed 38 → `err` pulse, `err_cnt`=1, `locked`=0, `expected`=37. Then feed 37, 36, 35, 34 → `locked`=1 again with no further `err`.
- Saturation (CNT_W=2 override): run 5 full 64-step cycles while locked → 5 `wrap` pulses, `wrap_cnt` stops at 3.
- Gapped enable and async reset: locked sequence with `en` high one cycle in three → lock is held. Assert `rst_n`=0 midway between edges → all outputs go to 0 before the next posedge. After release, the first sample only loads (state ACQ, `locked`=0).

Source files
------------

// File: rtl/verificador_decrescente_6bits.sv
// verificador_decrescente_6bits
//
// Self-check stage for the 6-bit ripple down-counter. The checker samples the
// counter value on every clock edge where en=1. It verifies that each sample
// is exactly one below the previous sample, modulo 2^WIDTH. After LOCK_N
// consecutive correct steps it declares lock. While locked it pulses `wrap`
// on every correct 0 -> max step and `err` on every mismatch. Both kinds of
// event are tallied in counters that saturate at their maximum value.
//
// Ports
//   clk       in   single clock, every state change happens on posedge
//   rst_n     in   asynchronous, active-low reset
//   en        in   sample strobe; q_in is sampled only when en=1
//   q_in      in   [WIDTH] counter value under check
//   locked    out  high while the sequence is being tracked correctly
//   err       out  one-cycle pulse on a mismatch while locked
//   wrap      out  one-cycle pulse on a correct 0 -> 2^WIDTH-1 step while locked
//   expected  out  [WIDTH] next value expected (last sample - 1)
//   wrap_cnt  out  [CNT_W] saturating count of wrap pulses
//   err_cnt   out  [CNT_W] saturating count of err pulses
module verificador_decrescente_6bits #(
  parameter int WIDTH  = 6,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // good_reg counts from 0 up to LOCK_N inclusive.
  localparam int GOOD_W = $clog2(LOCK_N + 1);

  localparam logic [WIDTH-1:0]  VAL_ONE  = WIDTH'(1);
  localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_N);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  prev_reg;
  logic [WIDTH-1:0]  expected_reg;
  logic [GOOD_W-1:0] good_reg;
  logic              locked_reg;
  logic              err_reg;
  logic              wrap_reg;
  logic [CNT_W-1:0]  wrap_cnt_reg;
  logic [CNT_W-1:0]  err_cnt_reg;

  logic [WIDTH-1:0]  prev_dec;
  logic [WIDTH-1:0]  q_dec;
  logic [GOOD_W-1:0] good_inc;
  logic              step_ok;
  logic              prev_zero;

  // The subtraction wraps, so prev=0 expects the all-ones value.
  assign prev_dec  = prev_reg - VAL_ONE;
  assign q_dec     = q_in - VAL_ONE;
  assign good_inc  = good_reg + GOOD_ONE;
  assign step_ok   = (q_in == prev_dec);
  assign prev_zero = (prev_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      prev_reg     <= '0;
      expected_reg <= '0;
      good_reg     <= '0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
      wrap_reg     <= 1'b0;
      wrap_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      // Event outputs are single-cycle pulses by default.
      err_reg  <= 1'b0;
      wrap_reg <= 1'b0;

      // Every sample becomes the new reference, whatever the state.
      if (en) begin
        prev_reg     <= q_in;
        expected_reg <= q_dec;
      end

      case (state_reg)
        EMPTY: begin
          // The first sample only seeds prev; nothing to compare yet.
          if (en) begin
            good_reg  <= '0;
            state_reg <= ACQ;
          end
        end

        ACQ: begin
          if (en) begin
            if (step_ok) begin
              good_reg <= good_inc;
              if (good_inc == GOOD_TGT) begin
                state_reg  <= LOCK;
                locked_reg <= 1'b1;
              end
            end else begin
              good_reg <= '0;
            end
          end
        end

        LOCK: begin
          if (en) begin
            if (step_ok) begin
              if (prev_zero) begin
                wrap_reg <= 1'b1;
                if (wrap_cnt_reg != CNT_MAX) wrap_cnt_reg <= wrap_cnt_reg + CNT_ONE;
              end
            end else begin
              err_reg    <= 1'b1;
              locked_reg <= 1'b0;
              good_reg   <= '0;
              state_reg  <= ACQ;
              if (err_cnt_reg != CNT_MAX) err_cnt_reg <= err_cnt_reg + CNT_ONE;
            end
          end
        end

        default: begin
          // The fourth encoding is unreachable. Recover to a clean start.
          state_reg  <= EMPTY;
          good_reg   <= '0;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign locked   = locked_reg;
  assign err      = err_reg;
  assign wrap     = wrap_reg;
  assign expected = expected_reg;
  assign wrap_cnt = wrap_cnt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule
